mux4_rr_arbiter: RTL
====================

# mux4_rr_arbiter

Round-robin arbiter and sequencer that shares a 4:1 multiplexer output channel among four requesters. It owns the mux select, issues a one-hot grant to exactly one requester at a time, and bounds each grant's tenure with a hold limit. It registers the selected input onto a single output with a valid flag. It sits in front of the 4:1 mux datapath (`in0`..`in3`, `sel`, `out`) and replaces free-running select stimulus with fair, request-driven sequencing.

## Interface
- `DATA_W`, 1: width of each data input and of `out`.
- `MAX_HOLD`, 8: maximum consecutive cycles a single grant stays asserted. Legal range is ≥ 1. `hold_cnt` width is $clog2(MAX_HOLD+1).

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  4  `req[i]` high while requester i wants the channel.
- `in0`, `in1`, `in2`, `in3`  in  DATA_W  data from requesters 0..3.
- `gnt`  out  4  one-hot grant, or all zero.
- `sel`  out  2  registered mux select; equals the index of the set `gnt` bit; holds its last value when `gnt` = 0.
- `out`  out  DATA_W  registered `in[sel]`.
- `out_valid`  out  1  `out` carries granted data.
- `busy`  out  1  high while in GRANT.

## Operation
- Reset values: `gnt`=0, `sel`=0, `out`=0, `out_valid`=0, `busy`=0, `ptr`=0, `hold_cnt`=0, state=IDLE. Reset overrides `req` in the same edge.
- `ptr` (2 bits) is the highest-priority index. Search order is `ptr`, `ptr`+1, `ptr`+2, `ptr`+3, mod 4. The first set `req` bit in that order wins.
- State IDLE (`gnt`=0):
  - If any `req` bit is set, load `sel` with the winner, set its `gnt` bit, clear `hold_cnt`, and go to GRANT.
  - Otherwise stay in IDLE.
- State GRANT (`gnt[sel]`=1): each edge, evaluate release. Release occurs if `req[sel]`=0 or `hold_cnt`=MAX_HOLD-1.
  - No release: increment `hold_cnt` and stay in GRANT.
  - Release: set `ptr` to `sel`+1 mod 4, then re-arbitrate in the same edge using the updated `ptr` and the current `req`.
    - Winner exists: grant it immediately (no idle cycle), clear `hold_cnt`, stay in GRANT.
    - No request pending: `gnt`=0, go to IDLE.
- The released requester is eligible in the same re-arbitration, but ranks last. A sole requester whose grant times out is re-granted back-to-back: `gnt` stays continuously high and `hold_cnt` restarts.
- Datapath, every edge:
  - `out_valid` gets (state==GRANT).
  - If in GRANT, `out` gets `in[sel]` using the pre-edge `sel`; otherwise `out` holds its value.
- `gnt` is never multi-hot. `sel` never changes while the same grant continues.

## Timing
- Request to grant: `req[i]` sampled high at edge k (IDLE) gives `gnt[i]`=1 and `sel`=i after edge k.
- Grant to data: `in_i` sampled at edge k+1 appears on `out` with `out_valid`=1 after edge k+1. Latency from grant to data is 1 cycle.
- Voluntary release: `req[i]` sampled low at edge m drops or switches `gnt` after edge m. `out_valid` falls, or carries the new requester's data, after edge m+1.
- Timeout: a single grant is visible for at most MAX_HOLD consecutive cycles.
- Handover between requesters takes zero bubble cycles, and `out_valid` stays high across it.
- Reset mid-grant: after the reset edge, all outputs are at reset values. The first grant after reset is possible at the first edge with `rst`=0.

## Test plan
- Reset, then `req`=4'b0000 for 5 cycles -> `gnt`=0, `sel`=0, `busy`=0, `out_valid`=0, `out`=0 throughout.
- `req`=4'b0100, `in2`=1, other inputs 0 -> after the next edge `gnt`=4'b0100 and `sel`=2. One edge later `out`=1 and `out_valid`=1. Drop `req` -> `gnt`=0 after the next edge, `out_valid`=0 one edge later.
- `req`=4'b1111 held, MAX_HOLD=8 -> grants rotate 0,1,2,3,0, each exactly 8 cycles, with no gap cycle and `out_valid` continuously high.
- Priority rotation: grant requester 1 and release it (`ptr`=2), then `req`=4'b0011 -> `gnt`=4'b0001, not 4'b0010.
- `req`=4'b0001 held 20 cycles, MAX_HOLD=8 -> `gnt`=4'b0001 continuously; `hold_cnt` wraps to 0 after each 8th cycle of the grant (every 8 cycles).
- Reset asserted on the 3rd cycle of a grant with `req`=4'b1000 still high -> all outputs are zero after that edge, and `gnt`=4'b1000 is re-granted one edge after `rst` deasserts.

Source files
------------

// File: rtl/mux4_rr_arbiter_if.sv
// Channel bundle between four requesters and the round-robin mux arbiter.
//   req[3:0]        request per requester
//   in0..in3        per-requester data
//   gnt[3:0]        one-hot grant (or zero)
//   sel[1:0]        registered mux select
//   out             registered selected data
//   out_valid       out carries granted data
//   busy            arbiter is in GRANT
// master: requester side, slave: arbiter side.
interface mux4_rr_arbiter_if #(
    parameter int unsigned DATA_W = 1
);
    logic [3:0]        req;
    logic [DATA_W-1:0] in0;
    logic [DATA_W-1:0] in1;
    logic [DATA_W-1:0] in2;
    logic [DATA_W-1:0] in3;
    logic [3:0]        gnt;
    logic [1:0]        sel;
    logic [DATA_W-1:0] out;
    logic              out_valid;
    logic              busy;

    modport master (
        output req, in0, in1, in2, in3,
        input  gnt, sel, out, out_valid, busy
    );

    modport slave (
        input  req, in0, in1, in2, in3,
        output gnt, sel, out, out_valid, busy
    );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning the select of a 4:1 mux. Grants one requester
// at a time, bounds each grant to MAX_HOLD cycles, registers in[sel] onto out.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   mux4_rr_arbiter_if.slave (req/in0..in3 in; gnt/sel/out/out_valid/busy out)
module mux4_rr_arbiter #(
    parameter int unsigned DATA_W   = 1,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    mux4_rr_arbiter_if.slave     bus
);
    localparam int unsigned        HOLD_W    = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [1:0]        sel_q, sel_d;
    logic [3:0]        gnt_q, gnt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;

    logic [1:0]        arb_ptr_c;
    logic [1:0]        arb_idx_c;
    logic [1:0]        arb_win_c;
    logic              arb_found_c;
    logic              release_c;
    logic [DATA_W-1:0] in_sel_c;

    // Current mux selection for the datapath (pre-edge sel).
    always_comb begin
        in_sel_c = bus.in0;
        case (sel_q)
            2'd0:    in_sel_c = bus.in0;
            2'd1:    in_sel_c = bus.in1;
            2'd2:    in_sel_c = bus.in2;
            default: in_sel_c = bus.in3;
        endcase
    end

    // Rotating-priority search. On a release the pointer moves to sel+1 in
    // the same edge, so the search starts there rather than at ptr_q.
    always_comb begin
        arb_ptr_c   = (state_q == GRANT) ? sel_q + 2'd1 : ptr_q;
        arb_found_c = 1'b0;
        arb_win_c   = arb_ptr_c;
        arb_idx_c   = arb_ptr_c;
        for (int i = 0; i < 4; i++) begin
            arb_idx_c = arb_ptr_c + 2'(i);
            if (!arb_found_c && bus.req[arb_idx_c]) begin
                arb_found_c = 1'b1;
                arb_win_c   = arb_idx_c;
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        sel_d       = sel_q;
        gnt_d       = gnt_q;
        hold_d      = hold_q;
        release_c   = (state_q == GRANT) &&
                      (!bus.req[sel_q] || (hold_q == HOLD_LAST));

        if ((state_q == IDLE) || release_c) begin
            if (state_q == GRANT) begin
                ptr_d = sel_q + 2'd1;
            end
            if (arb_found_c) begin
                state_d = GRANT;
                sel_d   = arb_win_c;
                gnt_d   = 4'b0001 << arb_win_c;
                hold_d  = '0;
            end else begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        end else begin
            hold_d = hold_q + HOLD_W'(1);
        end

        out_valid_d = (state_q == GRANT);
        out_d       = (state_q == GRANT) ? in_sel_c : out_q;
        busy_d      = (state_d == GRANT);
    end

    // State and output registers; reset wins over any request on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            sel_q       <= '0;
            gnt_q       <= '0;
            hold_q      <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            sel_q       <= sel_d;
            gnt_q       <= gnt_d;
            hold_q      <= hold_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.sel       = sel_q;
    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
endmodule
